pipe_stage_hs: RTL and testbench

//  Generic handshaked pipeline-stage register for the in-order core (F/D, D/E, E/M, M/W).
//  - Two-entry payload buffer: main + skid.
//  - Valid/ready flow control, so a stall never loses or duplicates an instruction.
//  - Flush squashes both entries and inserts NOP payloads.
//  - Programmable post-flush/post-reset bubble window blocks new input.

---
 rtl/pipe_stage_hs.sv | 117 +++++++++++
 tb/tb_pipe_stage_hs.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: handshaked two-entry (main + skid) pipeline-stage register
// with flush and a post-flush/post-reset bubble window.
//
// Ports:
//   clk           stage clock (active edge chosen by NEG_EDGE)
//   reset         asynchronous, active-low
//   flush         synchronous squash of both entries, reloads bubble window
//   in_valid      upstream payload valid
//   in_ready      stage accepts in_data this edge (from state only)
//   in_data       upstream payload
//   out_valid     out_data holds a live payload
//   out_ready     downstream consumes out_data this edge
//   out_data      payload, NOP_VALUE whenever out_valid=0
//   bubble_active bubble window counter nonzero
//   stall_cnt     (PIPE_STATS_EN only) saturating count of out_valid & ~out_ready edges
//   flush_cnt     (PIPE_STATS_EN only) saturating count of flush edges
//
// Optional feature macro: PIPE_STATS_EN
module pipe_stage_hs #(
    parameter int              DATA_W        = 64,
    parameter logic [DATA_W-1:0] NOP_VALUE   = '0,
    parameter int              FLUSH_BUBBLES = 1,
    parameter bit              NEG_EDGE      = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              bubble_active
`ifdef PIPE_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);
    localparam logic [3:0] BUB_INIT = 4'(FLUSH_BUBBLES);

    typedef struct packed {
        logic              main_v;
        logic              skid_v;
        logic [3:0]        bub;
        logic [DATA_W-1:0] main_d;
        logic [DATA_W-1:0] skid_d;
`ifdef PIPE_STATS_EN
        logic [31:0]       stall;
        logic [31:0]       flushes;
`endif
    } state_t;

    state_t r_st;
    state_t w_nxt;
    logic   w_accept;
    logic   w_consume;

    assign in_ready      = ~r_st.skid_v & (r_st.bub == 4'd0);
    assign out_valid     = r_st.main_v;
    assign out_data      = r_st.main_v ? r_st.main_d : NOP_VALUE;
    assign bubble_active = r_st.bub != 4'd0;
    assign w_accept      = in_valid & in_ready;
    assign w_consume     = r_st.main_v & out_ready;
`ifdef PIPE_STATS_EN
    assign stall_cnt = r_st.stall;
    assign flush_cnt = r_st.flushes;
`endif

    always_comb begin
        w_nxt = r_st;
        if (flush) begin
            w_nxt.main_v = 1'b0;
            w_nxt.skid_v = 1'b0;
            w_nxt.bub    = BUB_INIT;
        end else begin
            if (r_st.bub != 4'd0) w_nxt.bub = r_st.bub - 4'd1;
            // Main slot frees up: refill from skid first to keep FIFO order.
            // main_d may load unaccepted data; main_v gates it out.
            if (!r_st.main_v || w_consume) begin
                w_nxt.main_v = r_st.skid_v | w_accept;
                w_nxt.main_d = r_st.skid_v ? r_st.skid_d : in_data;
                w_nxt.skid_v = 1'b0;
            end else if (w_accept) begin
                w_nxt.skid_v = 1'b1;
                w_nxt.skid_d = in_data;
            end
        end
`ifdef PIPE_STATS_EN
        if (r_st.main_v && !out_ready && r_st.stall != '1) w_nxt.stall = r_st.stall + 32'd1;
        if (flush && r_st.flushes != '1) w_nxt.flushes = r_st.flushes + 32'd1;
`endif
    end

    generate
        if (NEG_EDGE) begin : g_neg
            always_ff @(negedge clk or negedge reset) begin
                if (!reset) begin
                    r_st     <= '0;
                    r_st.bub <= BUB_INIT;
                end else begin
                    r_st <= w_nxt;
                end
            end
        end else begin : g_pos
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_st     <= '0;
                    r_st.bub <= BUB_INIT;
                end else begin
                    r_st <= w_nxt;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: self-checking bench for pipe_stage_hs (vector table, corner sequences, random vs FIFO model)
module tb_pipe_stage_hs;
    localparam logic [63:0] NOP1 = 64'h0000_0000_0000_BAD0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        ir0, ov0, ba0, ir1, ov1, ba1;
    logic [63:0] od0, od1;
`ifdef PIPE_STATS_EN
    logic [31:0] stall_cnt, flush_cnt;
    logic [31:0] s1_unused, f1_unused;
`endif

    int tests = 0;
    int failed = 0;

    int          mn[2];
    logic [63:0] mq[2][2];
    int          mb[2];
    int          m_stall, m_flush;

    always #5 clk = ~clk;

    pipe_stage_hs #(.DATA_W(64), .FLUSH_BUBBLES(1), .NEG_EDGE(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
        .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .bubble_active(ba0)
`ifdef PIPE_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    pipe_stage_hs #(.DATA_W(64), .NOP_VALUE(NOP1), .FLUSH_BUBBLES(3), .NEG_EDGE(1'b1)) dut3 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
        .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .bubble_active(ba1)
`ifdef PIPE_STATS_EN
        , .stall_cnt(s1_unused), .flush_cnt(f1_unused)
`endif
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic [63:0] d;
        logic        orr;
        logic        e_ov;
        logic [63:0] e_od;
        logic        e_ir;
        logic        e_ba;
    } vec_t;

    vec_t vec[18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset();
        mn[0] = 0; mn[1] = 0;
        mb[0] = 1; mb[1] = 3;
        m_stall = 0; m_flush = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        model_reset();
    endtask

    // Stage modelled as a 2-deep FIFO plus a bubble countdown.
    task automatic model_step();
        logic rdy, acc;
        for (int k = 0; k < 2; k++) begin
            rdy = (mn[k] < 2) && (mb[k] == 0);
            acc = in_valid && rdy;
            if (k == 0 && mn[0] > 0 && !out_ready) m_stall++;
            if (flush) begin
                mn[k] = 0;
                mb[k] = (k == 0) ? 1 : 3;
            end else begin
                if (mb[k] > 0) mb[k]--;
                if (mn[k] > 0 && out_ready) begin
                    mq[k][0] = mq[k][1];
                    mn[k]--;
                end
                if (acc) begin
                    mq[k][mn[k]] = in_data;
                    mn[k]++;
                end
            end
        end
        if (flush) m_flush++;
    endtask

    task automatic model_check();
        chk("rnd0_in_ready", {63'd0, ir0}, {63'd0, (mn[0] < 2) && (mb[0] == 0)});
        chk("rnd0_out_valid", {63'd0, ov0}, {63'd0, mn[0] > 0});
        chk("rnd0_out_data", od0, (mn[0] > 0) ? mq[0][0] : 64'd0);
        chk("rnd0_bubble", {63'd0, ba0}, {63'd0, mb[0] != 0});
        chk("rnd1_in_ready", {63'd0, ir1}, {63'd0, (mn[1] < 2) && (mb[1] == 0)});
        chk("rnd1_out_valid", {63'd0, ov1}, {63'd0, mn[1] > 0});
        chk("rnd1_out_data", od1, (mn[1] > 0) ? mq[1][0] : NOP1);
        chk("rnd1_bubble", {63'd0, ba1}, {63'd0, mb[1] != 0});
`ifdef PIPE_STATS_EN
        chk("rnd_stall_cnt", {32'd0, stall_cnt}, 64'(m_stall));
        chk("rnd_flush_cnt", {32'd0, flush_cnt}, 64'(m_flush));
`endif
    endtask

    initial begin
        vec[0]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'h0,  1'b1, 1'b0};
        vec[1]  = '{1'b0, 1'b1, 64'h11, 1'b1, 1'b1, 64'h11, 1'b1, 1'b0};
        vec[2]  = '{1'b0, 1'b1, 64'h22, 1'b1, 1'b1, 64'h22, 1'b1, 1'b0};
        vec[3]  = '{1'b0, 1'b1, 64'h33, 1'b1, 1'b1, 64'h33, 1'b1, 1'b0};
        vec[4]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'h0,  1'b1, 1'b0};
        vec[5]  = '{1'b0, 1'b1, 64'hA,  1'b0, 1'b1, 64'hA,  1'b1, 1'b0};
        vec[6]  = '{1'b0, 1'b1, 64'hB,  1'b0, 1'b1, 64'hA,  1'b0, 1'b0};
        vec[7]  = '{1'b0, 1'b1, 64'hEE, 1'b0, 1'b1, 64'hA,  1'b0, 1'b0};
        vec[8]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b1, 64'hB,  1'b1, 1'b0};
        vec[9]  = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'h0,  1'b1, 1'b0};
        vec[10] = '{1'b0, 1'b1, 64'h1,  1'b0, 1'b1, 64'h1,  1'b1, 1'b0};
        vec[11] = '{1'b0, 1'b1, 64'h2,  1'b0, 1'b1, 64'h1,  1'b0, 1'b0};
        vec[12] = '{1'b1, 1'b1, 64'hC,  1'b1, 1'b0, 64'h0,  1'b0, 1'b1};
        vec[13] = '{1'b0, 1'b1, 64'hD,  1'b1, 1'b0, 64'h0,  1'b1, 1'b0};
        vec[14] = '{1'b0, 1'b1, 64'hE,  1'b1, 1'b1, 64'hE,  1'b1, 1'b0};
        vec[15] = '{1'b1, 1'b1, 64'hF,  1'b1, 1'b0, 64'h0,  1'b0, 1'b1};
        vec[16] = '{1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'h0,  1'b1, 1'b0};
        vec[17] = '{1'b0, 1'b1, 64'h44, 1'b0, 1'b1, 64'h44, 1'b1, 1'b0};

        do_reset();
        chk("reset_in_ready", {63'd0, ir0}, 64'd0);
        chk("reset_out_valid", {63'd0, ov0}, 64'd0);
        chk("reset_out_data", od0, 64'd0);
        chk("reset_bubble", {63'd0, ba0}, 64'd1);
        chk("reset_nop_masked", od1, NOP1);

        for (int i = 0; i < 18; i++) begin
            flush = vec[i].fl; in_valid = vec[i].iv; in_data = vec[i].d; out_ready = vec[i].orr;
            step();
            chk($sformatf("vec%0d_out_valid", i), {63'd0, ov0}, {63'd0, vec[i].e_ov});
            chk($sformatf("vec%0d_out_data", i), od0, vec[i].e_od);
            chk($sformatf("vec%0d_in_ready", i), {63'd0, ir0}, {63'd0, vec[i].e_ir});
            chk($sformatf("vec%0d_bubble", i), {63'd0, ba0}, {63'd0, vec[i].e_ba});
        end

        // Bubble window restart on a 3-edge stage.
        do_reset();
        flush = 1'b1; in_valid = 1'b1; in_data = 64'h77; out_ready = 1'b1;
        step();
        chk("b3_after_flush_ir", {63'd0, ir1}, 64'd0);
        chk("b3_after_flush_ba", {63'd0, ba1}, 64'd1);
        flush = 1'b0;
        step();
        chk("b3_edge1_ir", {63'd0, ir1}, 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b3_restart%0d_ir", i), {63'd0, ir1}, 64'd0);
            step();
        end
        chk("b3_window_done_ir", {63'd0, ir1}, 64'd1);
        chk("b3_window_done_ba", {63'd0, ba1}, 64'd0);
        chk("b3_no_accept_during_window", {63'd0, ov1}, 64'd0);

        // Random traffic against the FIFO model.
        do_reset();
        model_check();
        for (int n = 0; n < 2000; n++) begin
            flush = ($urandom % 25) == 0;
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            in_data = {$urandom, $urandom};
            model_step();
            step();
            model_check();
        end

`ifdef PIPE_STATS_EN
        do_reset();
        out_ready = 1'b1;
        step();
        in_valid = 1'b1; in_data = 64'h5;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        out_ready = 1'b1; flush = 1'b1;
        step();
        step();
        flush = 1'b0;
        chk("stats_stall_cnt", {32'd0, stall_cnt}, 64'd5);
        chk("stats_flush_cnt", {32'd0, flush_cnt}, 64'd2);
        reset = 1'b0;
        #1;
        chk("stats_reset_stall", {32'd0, stall_cnt}, 64'd0);
        chk("stats_reset_flush", {32'd0, flush_cnt}, 64'd0);
        step();
        reset = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
